// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid stages.
// Holds the occupancy state encoding and its next-state function.
package pipe_pkg;

  localparam int PIPE_DEFAULT_WIDTH = 64;

  // Number of valid beats held by the stage
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Occupancy after one edge.
  // accept and emit are the two handshakes; clr is a flush.
  // FULL never sees an accept because in_ready is low there.
  function automatic skid_state_t skid_next(skid_state_t st, logic acc, logic emt, logic clr);
    skid_state_t nx;
    nx = st;
    if (clr) begin
      nx = EMPTY;
    end else begin
      case (st)
        EMPTY:   if (acc) nx = ONE;
        ONE: begin
          if (acc && !emt)      nx = FULL;
          else if (!acc && emt) nx = EMPTY;
        end
        FULL:    if (emt) nx = ONE;
        default: nx = EMPTY;
      endcase
    end
    return nx;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable.
// Resets to RESET_VAL and holds whenever ld is low.
module pipe_data_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable only; contents survive while the entry is invalid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= RESET_VAL;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with valid/ready handshake and a one-entry skid.
// in_ready and out_valid come straight from flops, so nothing reaches
// in_ready combinationally from out_ready.
// Optional feature: define PIPE_SKID_REG_FLUSH_EN to add the flush input.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_SKID_REG_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state;
  skid_state_t      state_nx;
  logic             accept;
  logic             emit;
  logic             clr;
  logic             main_ld;
  logic             skid_ld;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

`ifdef PIPE_SKID_REG_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Load enables: flush blocks every load so a dropped beat never lands.
  // Main takes the fresh beat when it is (or is about to be) free, or
  // refills from skid when draining FULL; skid only catches a stalled accept.
  always_comb begin
    main_ld = 1'b0;
    skid_ld = 1'b0;
    if (!clr) begin
      case (state)
        EMPTY:   main_ld = accept;
        ONE: begin
          main_ld = accept & emit;
          skid_ld = accept & ~emit;
        end
        FULL:    main_ld = emit;
        default: ;
      endcase
    end
  end

  assign main_d   = (state == FULL) ? skid_q : in_data;
  assign state_nx = skid_next(state, accept, emit, clr);

  // Occupancy FSM; handshake outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != FULL);
      out_valid <= (state_nx != EMPTY);
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk   (clk),
    .reset (reset),
    .ld    (main_ld),
    .d     (main_d),
    .q     (out_data)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk   (clk),
    .reset (reset),
    .ld    (skid_ld),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule
